// File: rtl/cnt_sched_pkg.sv
// -----------------------------------------------------------------------------
// cnt_sched_pkg
//
// Purpose:
//   Shared definitions for the cnt_sched round-robin interval scheduler:
//   - the scheduler state enum (2-bit encoding)
//   - limits on the number of requesters and the matching pointer width
//   - a one-hot helper used to build grant and done vectors from an index
//
// Ports:
//   (package, no ports)
// -----------------------------------------------------------------------------
package cnt_sched_pkg;

    // Largest requester count the scheduler supports, and the pointer width
    // needed to address it. Instances use $clog2(N) bits of pointer and take
    // the low N bits of any one-hot vector built here.
    localparam int CNT_SCHED_MAX_N     = 16;
    localparam int CNT_SCHED_PTR_W_MAX = $clog2(CNT_SCHED_MAX_N);

    // Scheduler phases: waiting for a request, timing a slot, and the single
    // completion cycle that separates slots.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // One-hot vector with bit idx set. The result is sized for the largest
    // supported requester count, so callers cast it down to their own N.
    function automatic logic [CNT_SCHED_MAX_N-1:0] onehot(
        input logic [CNT_SCHED_PTR_W_MAX-1:0] idx
    );
        logic [CNT_SCHED_MAX_N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/cnt_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Purpose:
//   Combinational round-robin picker. It scans the requesters starting just
//   after the most recently serviced one and wraps at N, reporting the first
//   active request. The wrap is done by subtraction rather than by truncating
//   the pointer, so N does not need to be a power of two.
//
// Ports:
//   req    in   N       per-requester request level
//   last   in   PTR_W   index of the most recently serviced requester
//   valid  out  1       at least one request is active
//   index  out  PTR_W   chosen requester (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last,
    output logic             valid,
    output logic [PTR_W-1:0] index
);

    int cand;

    // Priority starts at last+1 and runs all the way around to last itself.
    // When the previous owner is the only requester it therefore wins again.
    // The first hit is kept and later hits are ignored.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand[PTR_W-1:0]]) begin
                valid = 1'b1;
                index = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// -----------------------------------------------------------------------------
// cnt_sched
//
// Purpose:
//   Round-robin scheduler that shares one up-counting interval counter among
//   N requesters. The winner of the arbitration owns the counter for dlat
//   cycles, where dlat is its latched duration (0 is treated as 1). The
//   scheduler then pulses that requester's done bit for one cycle and spends
//   one idle cycle before it grants the counter again.
//
// Optional feature (macro CNT_SCHED_ABORT_EN):
//   When the macro is defined and the owner drops its request while its slot
//   is being timed, the slot ends on the next cycle without a done pulse. The
//   owner still counts as serviced, so the round-robin pointer moves past it.
//   When the macro is undefined, the owner's request is ignored once it has
//   been granted.
//
// Ports:
//   clk    in   1     system clock, all state updates on posedge
//   rst    in   1     synchronous active-high reset
//   req    in   N     per-requester request level
//   dur    in   N*W   per-requester duration, requester i at [i*W +: W]
//   grant  out  N     one-hot current owner of the counter, zero when free
//   done   out  N     one-cycle completion pulse to the serviced requester
//   busy   out  1     high while a slot is being timed or completed
//   cnt    out  W     current value of the shared counter
// -----------------------------------------------------------------------------
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] dur,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   cnt
);

    localparam int PTR_W = $clog2(N);

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [N-1:0]     done_q,  done_d;
    logic             busy_q,  busy_d;
    logic [W-1:0]     cnt_q,   cnt_d;
    logic [W-1:0]     dlat_q,  dlat_d;
    logic [PTR_W-1:0] last_q,  last_d;
    logic [PTR_W-1:0] owner_q, owner_d;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [W-1:0]     pick_dur;

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Select the winner's duration with constant part-select bases. This
    // avoids a variable-width index into the packed duration bus.
    always_comb begin
        pick_dur = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_dur = dur[i*W +: W];
            end
        end
    end

    // Next-state logic for the scheduler.
    // IDLE grants to the picker's winner and latches its duration.
    // COUNT times the slot, ending when cnt reaches dlat-1 so that grant is
    // high for exactly dlat cycles.
    // DONE carries the one-cycle pulse and records the owner as last. This
    // makes the next arbitration, one idle cycle later, start just past it.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        dlat_d  = dlat_q;
        last_d  = last_q;
        owner_d = owner_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                if (pick_valid) begin
                    state_d = COUNT;
                    grant_d = N'(onehot(CNT_SCHED_PTR_W_MAX'(pick_idx)));
                    busy_d  = 1'b1;
                    owner_d = pick_idx;
                    dlat_d  = (pick_dur == '0) ? W'(1) : pick_dur;
                end
            end

            COUNT: begin
`ifdef CNT_SCHED_ABORT_EN
                // A dropped owner request outranks the terminal count. The
                // owner is still recorded as serviced.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    last_d  = owner_q;
                end else
`endif
                if (cnt_q == dlat_q - W'(1)) begin
                    state_d = DONE;
                    grant_d = '0;
                    done_d  = N'(onehot(CNT_SCHED_PTR_W_MAX'(owner_q)));
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                last_d  = owner_q;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Every piece of scheduler state and every output is registered here.
    // Reset wins over everything else and abandons any slot in flight without
    // a done pulse. last resets to N-1 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            dlat_q  <= W'(1);
            last_q  <= PTR_W'(N - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            dlat_q  <= dlat_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign cnt   = cnt_q;

endmodule

// File: tb/tb_cnt_sched.sv
// -----------------------------------------------------------------------------
// tb_cnt_sched
//
// Purpose:
//   Self-checking bench for cnt_sched with N=4 and W=8. It covers:
//   - table-driven single-service cases
//   - hand-written multi-cycle sequences: round robin, late arrival,
//     reset mid-count, and owner drop
//   - randomized traffic checked against a slot-level reference model
//   Its behaviour follows macro CNT_SCHED_ABORT_EN in the same way as the
//   design.
//
// Ports:
//   (none)
// -----------------------------------------------------------------------------
module tb_cnt_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] dur;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, tracked at the level of service slots.
    int m_owner;
    int m_done_owner;
    int m_elapsed;
    int m_len;
    int m_last;

    typedef struct {
        logic [N-1:0] req_v;
        logic [W-1:0] dur_v;
        logic [N-1:0] exp_grant;
        int           exp_len;
    } vec_t;

    vec_t vecs[6];

    cnt_sched #(
        .N (N),
        .W (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dur   (dur),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .cnt   (cnt)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case a wait somewhere fails to terminate.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d);
        req = r;
        dur = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [N*W-1:0] allDur(input logic [W-1:0] v);
        return {N{v}};
    endfunction

    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Finish the current grant, if any, then wait for the next one and
    // compare its owner.
    task automatic waitGrant(input string name, input logic [N-1:0] exp);
        int b;
        b = 0;
        while (grant != '0 && b < 600) begin
            tick();
            b++;
        end
        b = 0;
        while (grant == '0 && b < 600) begin
            tick();
            b++;
        end
        checkOutput(name, 32'(grant), 32'(exp));
    endtask

    // Reference model, advanced once per clock edge using the inputs that
    // edge will sample. A slot lasts max(dur,1) cycles. It is followed by a
    // one-cycle done pulse and one free cycle. Winners are found by scanning
    // from last+1 around the ring.
    task automatic modelStep(input logic r_rst, input logic [N-1:0] r,
                             input logic [N*W-1:0] d);
        int  c;
        bit  aborted;
        int  dv;
        aborted = 1'b0;
        if (r_rst) begin
            m_owner      = -1;
            m_done_owner = -1;
            m_elapsed    = 0;
            m_len        = 0;
            m_last       = N - 1;
        end else if (m_done_owner >= 0) begin
            m_last       = m_done_owner;
            m_done_owner = -1;
        end else if (m_owner >= 0) begin
`ifdef CNT_SCHED_ABORT_EN
            if (!r[m_owner]) begin
                m_last    = m_owner;
                m_owner   = -1;
                m_elapsed = 0;
                aborted   = 1'b1;
            end
`endif
            if (!aborted) begin
                if (m_elapsed == m_len - 1) begin
                    m_done_owner = m_owner;
                    m_owner      = -1;
                    m_elapsed    = 0;
                end else begin
                    m_elapsed++;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_owner < 0 && r[c]) begin
                    m_owner   = c;
                    m_elapsed = 0;
                    dv        = int'(d[c*W +: W]);
                    m_len     = (dv == 0) ? 1 : dv;
                end
            end
        end
    endtask

    initial begin
        logic [N-1:0] g;
        int           len;
        int           max_cnt;
        int           seq_bad;
        int           b;
        logic [N-1:0] r_rand;
        logic [N*W-1:0] d_rand;
        logic           rst_rand;
        int           exp_grant;
        int           exp_done;

        rst = 1'b1;
        req = '0;
        dur = '0;

        $display("[TB] table-driven single-service cases");
        vecs[0] = '{req_v: 4'b0001, dur_v: 8'd5,   exp_grant: 4'b0001, exp_len: 5};
        vecs[1] = '{req_v: 4'b0010, dur_v: 8'd0,   exp_grant: 4'b0010, exp_len: 1};
        vecs[2] = '{req_v: 4'b0010, dur_v: 8'd255, exp_grant: 4'b0010, exp_len: 255};
        vecs[3] = '{req_v: 4'b1000, dur_v: 8'd2,   exp_grant: 4'b1000, exp_len: 2};
        vecs[4] = '{req_v: 4'b0110, dur_v: 8'd3,   exp_grant: 4'b0010, exp_len: 3};
        vecs[5] = '{req_v: 4'b1100, dur_v: 8'd1,   exp_grant: 4'b0100, exp_len: 1};

        for (int v = 0; v < 6; v++) begin
            doReset();
            checkOutput("reset_grant", 32'(grant), 32'd0);
            checkOutput("reset_done",  32'(done),  32'd0);
            checkOutput("reset_busy",  32'(busy),  32'd0);
            checkOutput("reset_cnt",   32'(cnt),   32'd0);
            applyStimulus(vecs[v].req_v, allDur(vecs[v].dur_v));
            tick();
            checkOutput("vec_first_grant", 32'(grant), 32'(vecs[v].exp_grant));
            checkOutput("vec_busy_on",     32'(busy),  32'd1);
            len     = 0;
            max_cnt = 0;
            seq_bad = 0;
            while (grant != '0 && len < 400) begin
                if (int'(cnt) != len) seq_bad++;
                if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
                len++;
                tick();
            end
            checkOutput("vec_grant_len",  32'(len),     32'(vecs[v].exp_len));
            checkOutput("vec_cnt_seq",    32'(seq_bad), 32'd0);
            checkOutput("vec_cnt_max",    32'(max_cnt), 32'(vecs[v].exp_len - 1));
            checkOutput("vec_done_pulse", 32'(done),    32'(vecs[v].exp_grant));
            checkOutput("vec_done_busy",  32'(busy),    32'd1);
            checkOutput("vec_done_cnt",   32'(cnt),     32'd0);
            applyStimulus('0, '0);
            tick();
            checkOutput("vec_done_clear", 32'(done),  32'd0);
            checkOutput("vec_busy_off",   32'(busy),  32'd0);
            checkOutput("vec_idle_grant", 32'(grant), 32'd0);
        end

        $display("[TB] round robin with all requests held");
        doReset();
        applyStimulus(4'b1111, allDur(8'd2));
        tick();
        for (int s = 0; s < 5; s++) begin
            g = 4'b0001 << (s % N);
            checkOutput("rr_grant_c0", 32'(grant), 32'(g));
            tick();
            checkOutput("rr_grant_c1", 32'(grant), 32'(g));
            tick();
            checkOutput("rr_done_grant", 32'(grant), 32'd0);
            checkOutput("rr_done",       32'(done),  32'(g));
            tick();
            checkOutput("rr_idle_done",  32'(done),  32'd0);
            checkOutput("rr_idle_grant", 32'(grant), 32'd0);
            tick();
        end

        $display("[TB] late arrival during service");
        doReset();
        applyStimulus(4'b0001, allDur(8'd4));
        tick();
        tick();
        applyStimulus(4'b0101, allDur(8'd4));
        waitGrant("late_next_is_2", 4'b0100);
        waitGrant("late_then_0",    4'b0001);

        $display("[TB] reset in the middle of a count");
        doReset();
        applyStimulus(4'b0011, allDur(8'd10));
        tick();
        b = 0;
        while (cnt != 8'd3 && b < 20) begin
            tick();
            b++;
        end
        checkOutput("midrst_cnt_reached", 32'(cnt), 32'd3);
        rst = 1'b1;
        tick();
        checkOutput("midrst_grant", 32'(grant), 32'd0);
        checkOutput("midrst_cnt",   32'(cnt),   32'd0);
        checkOutput("midrst_busy",  32'(busy),  32'd0);
        checkOutput("midrst_done",  32'(done),  32'd0);
        rst = 1'b0;
        tick();
        checkOutput("midrst_first_owner", 32'(grant), 32'd1);

        $display("[TB] owner drops request at cnt=2");
        doReset();
        applyStimulus(4'b0011, allDur(8'd6));
        tick();
        tick();
        tick();
        checkOutput("drop_cnt_at_2", 32'(cnt), 32'd2);
        applyStimulus(4'b0010, allDur(8'd6));
        tick();
`ifdef CNT_SCHED_ABORT_EN
        checkOutput("abort_grant", 32'(grant), 32'd0);
        checkOutput("abort_done",  32'(done),  32'd0);
        checkOutput("abort_cnt",   32'(cnt),   32'd0);
        checkOutput("abort_busy",  32'(busy),  32'd0);
        tick();
        checkOutput("abort_next_owner", 32'(grant), 32'd2);
`else
        len = 3;
        b   = 0;
        while (grant == 4'b0001 && b < 20) begin
            len++;
            b++;
            tick();
        end
        checkOutput("nodrop_grant_len", 32'(len),  32'd6);
        checkOutput("nodrop_done",      32'(done), 32'd1);
        waitGrant("nodrop_next_owner", 4'b0010);
`endif

        $display("[TB] randomized traffic against reference model");
        r_rand = '0;
        d_rand = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_rand = (cyc == 0) || ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 3) r_rand = N'($urandom);
            for (int i = 0; i < N; i++) begin
                d_rand[i*W +: W] = ($urandom_range(0, 15) == 0) ?
                                   W'(0) : W'($urandom_range(1, 6));
            end
            rst = rst_rand;
            applyStimulus(r_rand, d_rand);
            modelStep(rst_rand, r_rand, d_rand);
            tick();
            exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
            exp_done  = (m_done_owner >= 0) ? (1 << m_done_owner) : 0;
            checkOutput("rand_grant", 32'(grant), 32'(exp_grant));
            checkOutput("rand_done",  32'(done),  32'(exp_done));
            checkOutput("rand_busy",  32'(busy),  32'((m_owner >= 0) || (m_done_owner >= 0)));
            checkOutput("rand_cnt",   32'(cnt),   32'((m_owner >= 0) ? m_elapsed : 0));
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
Round-robin scheduler that shares one up-counting interval counter among N requesters. Each requester supplies a duration; the scheduler grants the counter to one requester at a time, counts that many cycles and pulses a per-requester done. It sits beside the basic counter blocks as their sequencer and arbiter, for timed-slot access to a single timer resource.

Parameters:
N, 4, number of requesters (2..16)
W, 8, counter and duration width in bits

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
req  in  N  per-requester request level
dur  in  N*W  per-requester duration; requester i uses bits [i*W +: W]
grant  out  N  one-hot owner of the counter; all zero when free
done  out  N  one-cycle completion pulse to the serviced requester
busy  out  1  high in COUNT and DONE
cnt  out  W  current count value of the shared counter

Behaviour:
- Reset values, applied when rst is 1 at a posedge and taking priority over all else: state=IDLE, grant=0, done=0, busy=0, cnt=0, last=N-1, so requester 0 wins first.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req != 0, pick the first asserted req scanning last+1, last+2, ... modulo N.
  - Next cycle: state=COUNT, grant=onehot(i), cnt=0, busy=1.
  - Latch dlat = dur[i]; a dur of 0 is latched as 1.
  - Grant latency from req seen in IDLE is 1 cycle.
- COUNT:
  - cnt increments by 1 each cycle.
  - When cnt == dlat-1: next cycle state=DONE, grant=0, done[i]=1, cnt=0.
  - grant is high for exactly dlat cycles. cnt shows 0..dlat-1 and never wraps, because dlat <= 2^W-1.
  - dur and other req changes are ignored while counting.
- DONE:
  - done[i] high for exactly one cycle; busy=1.
  - last=i; next state=IDLE.
  - done and grant are never high in the same cycle.
- Back-to-back service: minimum spacing from end of one grant to start of the next is 2 cycles (DONE, then IDLE).
- Fairness: with all requests held, service order is 0,1,2,...,N-1,0,...
- A single continuous requester is re-served after each DONE/IDLE pair.
- Simultaneous events:
  - A new req arriving during COUNT or DONE waits and is evaluated in IDLE.
  - A req dropped during DONE has no effect.
- Reset mid-operation: the whole sequence is abandoned immediately, no done is emitted, and state returns to the reset values above.
- Widths: cnt compare is W-bit unsigned. The pointer is $clog2(N) bits, with wrap at N handled explicitly for non-power-of-two N.

Optional Feature:
Macro: CNT_SCHED_ABORT_EN
- Defined:
  - In COUNT, if req[i] of the owner drops, next cycle state=IDLE, grant=0, cnt=0, no done pulse.
  - last=i, so the pointer still advances and the requester is treated as serviced.
  - Abort check has priority over the terminal-count check in the same cycle.
- Not defined: req of the owner is ignored after grant; service always runs to done.

Decomposition:
- Package cnt_sched_pkg: state enum (IDLE, COUNT, DONE) with a 2-bit encoding; localparam for pointer width; a function for onehot(index).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N], last pointer.
  - Outputs: valid, index.
  - Instantiated once.
- The FSM, counter and latches stay in cnt_sched.

Test Plan:
1. Reset then single request: rst high for 2 cycles, then req=0001, dur0=5. Expect grant=0001 on the cycle after req is seen, held 5 cycles with cnt 0..4, then done=0001 for 1 cycle, grant=0, busy falls 1 cycle later.
2. Round-robin: req=1111 held, all dur=2. Expect grant order 0001, 0010, 0100, 1000, 0001, each held 2 cycles, separated by one DONE and one IDLE cycle.
3. Zero and max duration: dur1=0 gives a 1-cycle grant. dur1=255 (W=8) gives a 255-cycle grant with cnt reaching 254 and no wrap.
4. Late arrival and fairness: req0 held; req2 rises mid-service of 0. Expect requester 2 served next, then requester 0.
5. Reset mid-count: rst asserted while cnt=3 of dur=10. Expect next cycle grant=0, cnt=0, busy=0, no done, and requester 0 served first afterwards.
6. With CNT_SCHED_ABORT_EN: owner drops req at cnt=2 of dur=6. Expect grant=0 next cycle, no done, and the next grant goes to the following requester in round-robin order. Without the macro, the same stimulus gives the full 6-cycle grant and done.
